// File: rtl/alu_postprocess.sv
// ALU output stage: captures adder results, derives Z/N/C/V flags and buffers
// them in a 2-entry valid/ready FIFO with a sticky overflow flag and pop counter.
module alu_postprocess #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [3:0]       amod,
  input  logic [3:0]       bmod,
  input  logic [3:0]       sum,
  input  logic             cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       r,
  output logic [2:0]       r_op,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             v_sticky,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] op_count
);

  typedef struct packed {
    logic [2:0] op;
    logic       z;
    logic       n;
    logic       c;
    logic       v;
    logic [3:0] res;
  } entry_t;

  logic [1:0] cnt;
  entry_t     head;
  entry_t     tail;
  entry_t     new_entry;
  logic       push;
  logic       pop;

  assign in_ready  = (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    new_entry     = '0;
    new_entry.op  = op;
    new_entry.z   = (sum == 4'd0);
    new_entry.n   = sum[3];
    new_entry.c   = cout;
    new_entry.v   = (amod[3] == bmod[3]) && (sum[3] != amod[3]);
    new_entry.res = sum;
  end

  // Head register feeds the outputs directly; tail only holds the second entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else begin
      case (cnt)
        2'd0: begin
          if (push) begin
            head <= new_entry;
            cnt  <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head <= new_entry;
          end else if (push) begin
            tail <= new_entry;
            cnt  <= 2'd2;
          end else if (pop) begin
            cnt  <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head <= tail;
            cnt  <= 2'd1;
          end
        end
      endcase
    end
  end

  assign r      = head.res;
  assign r_op   = head.op;
  assign flag_z = head.z;
  assign flag_n = head.n;
  assign flag_c = head.c;
  assign flag_v = head.v;

  // Set has priority over clear so an overflow in the clearing cycle is not lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_sticky <= 1'b0;
    end else if (push && new_entry.v) begin
      v_sticky <= 1'b1;
    end else if (clr_sticky) begin
      v_sticky <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_count <= '0;
    end else if (pop && (op_count != {CNT_W{1'b1}})) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_postprocess.sv
// Directed bench for alu_postprocess with a 2-bit op counter so saturation is reachable.
module tb_alu_postprocess;

  localparam int CNT_W = 2;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [3:0]       amod;
  logic [3:0]       bmod;
  logic [3:0]       sum;
  logic             cout;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       r;
  logic [2:0]       r_op;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;
  logic             v_sticky;
  logic             clr_sticky;
  logic [CNT_W-1:0] op_count;

  int tests = 0;
  int fails = 0;

  alu_postprocess #(.DEPTH(2), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .amod       (amod),
    .bmod       (bmod),
    .sum        (sum),
    .cout       (cout),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .r          (r),
    .r_op       (r_op),
    .flag_z     (flag_z),
    .flag_n     (flag_n),
    .flag_c     (flag_c),
    .flag_v     (flag_v),
    .v_sticky   (v_sticky),
    .clr_sticky (clr_sticky),
    .op_count   (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [3:0] a,
                       input logic [3:0] b, input logic [3:0] s, input logic c);
    in_valid = v;
    op       = o;
    amod     = a;
    bmod     = b;
    sum      = s;
    cout     = c;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    out_ready  = 1'b0;
    clr_sticky = 1'b0;
    drive(1'b1, 3'd7, 4'd7, 4'd7, 4'd7, 1'b1);

    // reset held with in_valid high: nothing may enter
    repeat (3) step();
    chk("rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_in_ready",  {7'd0, in_ready},  8'd1);
    chk("rst_r",         {4'd0, r},         8'd0);
    chk("rst_op_count",  {6'd0, op_count},  8'd0);
    chk("rst_v_sticky",  {7'd0, v_sticky},  8'd0);

    // single add with overflow: 5 + 3 = 8
    reset_n   = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 3'b010, 4'd5, 4'd3, 4'd8, 1'b0);
    step();
    chk("ovf_out_valid", {7'd0, out_valid}, 8'd1);
    chk("ovf_r",         {4'd0, r},         8'd8);
    chk("ovf_r_op",      {5'd0, r_op},      8'd2);
    chk("ovf_flags_znc_v", {4'd0, flag_z, flag_n, flag_c, flag_v}, 8'b0101);
    chk("ovf_v_sticky",  {7'd0, v_sticky},  8'd1);
    drive(1'b0, 3'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    step();
    chk("ovf_popped",    {7'd0, out_valid}, 8'd0);
    chk("ovf_op_count",  {6'd0, op_count},  8'd1);
    chk("ovf_r_hold",    {4'd0, r},         8'd8);

    // zero with carry: 1 + F = 0, cout=1
    out_ready = 1'b0;
    drive(1'b1, 3'b001, 4'd1, 4'hF, 4'd0, 1'b1);
    step();
    chk("zc_flags_znc_v", {4'd0, flag_z, flag_n, flag_c, flag_v}, 8'b1010);
    chk("zc_r_op",       {5'd0, r_op},      8'd1);
    out_ready = 1'b1;
    drive(1'b0, 3'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    step();
    chk("zc_op_count",   {6'd0, op_count},  8'd2);

    // backpressure: three results with out_ready low
    pulse_reset();
    out_ready = 1'b0;
    drive(1'b1, 3'd3, 4'd0, 4'd1, 4'd1, 1'b0);
    step();
    chk("bp_ready_1",    {7'd0, in_ready},  8'd1);
    drive(1'b1, 3'd3, 4'd0, 4'd2, 4'd2, 1'b0);
    step();
    chk("bp_ready_full", {7'd0, in_ready},  8'd0);
    drive(1'b1, 3'd3, 4'd0, 4'd3, 4'd3, 1'b0);
    step();
    chk("bp_ready_held", {7'd0, in_ready},  8'd0);
    chk("bp_head_1",     {4'd0, r},         8'd1);
    out_ready = 1'b1;
    step();
    chk("bp_head_2",     {4'd0, r},         8'd2);
    chk("bp_ready_after_pop", {7'd0, in_ready}, 8'd1);
    step();
    chk("bp_head_3",     {4'd0, r},         8'd3);
    chk("bp_count_2",    {6'd0, op_count},  8'd2);
    drive(1'b0, 3'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    step();
    chk("bp_empty",      {7'd0, out_valid}, 8'd0);
    chk("bp_count_3",    {6'd0, op_count},  8'd3);

    // push+pop at cnt=1 with simultaneous sticky clear
    pulse_reset();
    out_ready = 1'b0;
    drive(1'b1, 3'd4, 4'd2, 4'd2, 4'd4, 1'b0);
    step();
    chk("pp_sticky_0",   {7'd0, v_sticky},  8'd0);
    out_ready  = 1'b1;
    clr_sticky = 1'b1;
    drive(1'b1, 3'd5, 4'd5, 4'd3, 4'd8, 1'b0);
    step();
    chk("pp_sticky_set_wins", {7'd0, v_sticky}, 8'd1);
    chk("pp_out_valid",  {7'd0, out_valid}, 8'd1);
    chk("pp_in_ready",   {7'd0, in_ready},  8'd1);
    chk("pp_head_new",   {4'd0, r},         8'd8);
    chk("pp_head_op",    {5'd0, r_op},      8'd5);
    chk("pp_count",      {6'd0, op_count},  8'd1);
    out_ready = 1'b0;
    drive(1'b0, 3'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    step();
    chk("pp_sticky_clr", {7'd0, v_sticky},  8'd0);
    chk("pp_head_hold",  {4'd0, r},         8'd8);
    clr_sticky = 1'b0;

    // negative overflow: 8 + 8 = 0 with carry
    pulse_reset();
    drive(1'b1, 3'd6, 4'd8, 4'd8, 4'd0, 1'b1);
    step();
    chk("nov_flags_znc_v", {4'd0, flag_z, flag_n, flag_c, flag_v}, 8'b1011);

    // saturation: 5 pops on a 2-bit counter, then reset with 2 entries buffered
    pulse_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 3'd0, 4'd0, 4'(i), 4'(i), 1'b0);
      step();
    end
    chk("sat_count",     {6'd0, op_count},  8'd3);
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 4'd0, 4'd7, 4'd7, 1'b0);
    step();
    chk("sat_full",      {7'd0, in_ready},  8'd0);
    chk("sat_head",      {4'd0, r},         8'd6);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", {7'd0, out_valid}, 8'd0);
    chk("mid_rst_count",     {6'd0, op_count},  8'd0);
    chk("mid_rst_in_ready",  {7'd0, in_ready},  8'd1);
    chk("mid_rst_r",         {4'd0, r},         8'd0);
    drive(1'b0, 3'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    step();
    reset_n = 1'b1;
    step();
    chk("post_rst_empty",    {7'd0, out_valid}, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
